masked_sbox_random_gen: RTL and testbench
=========================================

# masked_sbox_random_gen

Seeded, warm-up-gated pseudo-random source that produces the fresh masking randomness for the masked Canright GF(2^8) inverter on every enabled cycle. It sits directly upstream of the inverter and drives its `in_random` bus, which carries the front multiplier, bv4 inverse and stage-4 randomness in one word. The source is a 128-bit Fibonacci LFSR advanced NUM_RANDOM steps per cycle. A small FSM sequences seeding, warm-up and run, and raises a reseed request after a programmable number of words.

## Interface
- NUM_SHARES, 2, share count of the consuming inverter
- STAGE_TYPE, DEFAULT_STAGE_TYPE, stage-4 gadget type (HPC1/HPC3) of the consumer
- NUM_RANDOM, num_canright_inv_random(NUM_SHARES, STAGE_TYPE), output width in bits
- WARMUP_CYCLES, 16, discarded cycles after each seed; 0 allowed
- RESEED_INTERVAL, 0, words delivered before out_reseed_req rises; 0 disables the request
- in_clock  in  1  clock; the single clock of the block
- in_reset  in  1  reset; asynchronous and active-high
- in_seed  in  128  seed value
- in_seed_valid  in  1  seed offered
- out_seed_ready  out  1  seed acceptance possible this cycle
- in_enable  in  1  consumer takes out_random this cycle
- out_random  out  NUM_RANDOM  randomness word; connects to the inverter's in_random
- out_random_valid  out  1  out_random is usable
- out_reseed_req  out  1  interval exhausted, new seed wanted

## Operation
- LFSR state s[127:0]. One step: output bit o = s[127]; feedback f = s[127]^s[126]^s[125]^s[120] (x^128+x^127+x^126+x^121+1); s <= {s[126:0], f}.
- out_random[j] is the o emitted at step j from the current state, for j = 0..NUM_RANDOM-1. For j < 128 this is s[127-j], a plain wire. It is a pure function of the state register, with no extra register.
- FSM states: IDLE (unseeded), WARMUP, RUN.
- Seed accept occurs when in_seed_valid & out_seed_ready. The state loads in_seed. An all-zero seed is replaced by 128'h1 to avoid lock-up.
- IDLE: out_seed_ready=1, valid=0, the state holds. On accept, go to WARMUP, or to RUN if WARMUP_CYCLES==0.
- WARMUP: out_seed_ready=0, valid=0. The state advances NUM_RANDOM steps every cycle, ignoring in_enable. The counter counts up to WARMUP_CYCLES, then the FSM goes to RUN.
- RUN: out_seed_ready=1, valid=1. If in_enable=1, the state advances NUM_RANDOM steps and the word counter increments; otherwise the state holds.
- Reseed in RUN: seed acceptance wins over in_enable in the same cycle. The state loads the seed (no advance) and the FSM goes to WARMUP, or stays in RUN if WARMUP_CYCLES==0.
- Word counter: cleared on seed accept and saturates at RESEED_INTERVAL. out_reseed_req = (RESEED_INTERVAL!=0) & (count==RESEED_INTERVAL) & RUN. Generation continues while the request is high.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream): FSM=IDLE, s=0, counters=0.
- During reset: out_random=0, valid=0, out_reseed_req=0, out_seed_ready=1.
- Seed accepted at edge k:
  - valid rises after edge k+WARMUP_CYCLES; for WARMUP_CYCLES=0 it rises immediately after edge k.
  - The first valid word reflects the seed advanced WARMUP_CYCLES·NUM_RANDOM steps.
- Words change only on edges where RUN & in_enable hold. A word is consumed in the cycle in_enable is high and is replaced at the next edge.
- in_enable outside RUN is ignored.
- Reset asserted mid-WARMUP or mid-RUN returns to IDLE immediately. The seed is lost and must be reloaded.

## Structure
- aes128_package gains:
  - PRNG_STATE_WIDTH=128
  - PRNG tap constant
  - function prng_steps(state, n) returning {next_state, n output bits}, shared by RTL and bench model
- The existing num_canright_inv_random supplies the default NUM_RANDOM.
- Sub-module prng_lfsr128_unrolled (combinational, parameter STEPS) computes the next state and the output word.
- The top module holds the FSM, the state register (via the existing register module), the warm-up counter (clog2(WARMUP_CYCLES+1) bits) and the word counter.

## Test plan
- Reset, no seed -> out_random=0, valid=0, seed_ready=1 and reseed_req=0, held for 10 cycles regardless of in_enable.
- WARMUP_CYCLES=0, seed 128'h1 -> valid in the next cycle. out_random[j]=0 for j<min(NUM_RANDOM,127); bit 127, if present, =1.
- Seed 128'h0 -> behaves exactly as seed 128'h1 (compare streams word by word).
- WARMUP_CYCLES=16, random seed -> valid rises exactly 16 cycles after accept, seed_ready=0 throughout. Words match prng_steps with in_enable toggled pseudo-randomly; the word holds while in_enable=0.
- RESEED_INTERVAL=5 -> reseed_req rises after the 5th enabled word and stays high. Reseed with in_enable=1 in the same cycle -> the seed wins, valid drops, and reseed_req clears.
- Async reset pulse mid-WARMUP and mid-RUN (off-edge) -> outputs return to reset values immediately. A new seed restarts the sequence identically to the first run.

Source files
------------

// File: rtl/masked_sbox_random_gen_pkg.sv
// Shared types, LFSR constants and step functions for the masking-randomness source.
// Pure declarations: no latency, no flow control.
package masked_sbox_random_gen_pkg;

    localparam int PRNG_STATE_WIDTH = 128;
    // Feedback taps for x^128+x^127+x^126+x^121+1, as a mask over s[127:0] (bits 127,126,125,120)
    localparam logic [PRNG_STATE_WIDTH-1:0] PRNG_TAPS = 128'hE100_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [PRNG_STATE_WIDTH-1:0] PRNG_ZERO_SEED_SUB = 128'h1;
    localparam int PRNG_MAX_OUT = 256;

    typedef enum logic {
        STAGE_HPC1,
        STAGE_HPC3
    } stage_type_e;

    localparam stage_type_e DEFAULT_STAGE_TYPE = STAGE_HPC3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } gen_state_e;

    typedef struct packed {
        logic [PRNG_MAX_OUT-1:0]     bits;
        logic [PRNG_STATE_WIDTH-1:0] state;
    } prng_res_t;

    // Per share pair: front GF(16) multiplier 4, bv4 inverse 4, stage-4 multipliers 8; HPC1 adds an 8-bit refresh
    function automatic int num_canright_inv_random(input int num_shares, input stage_type_e stage);
        int pairs;
        pairs = num_shares * (num_shares - 1) / 2;
        return (stage == STAGE_HPC1) ? 24 * pairs : 16 * pairs;
    endfunction

    // One LFSR step: {next_state, emitted bit}
    function automatic logic [PRNG_STATE_WIDTH:0] prng_step(input logic [PRNG_STATE_WIDTH-1:0] s);
        return {s[PRNG_STATE_WIDTH-2:0], ^(s & PRNG_TAPS), s[PRNG_STATE_WIDTH-1]};
    endfunction

    function automatic prng_res_t prng_steps(input logic [PRNG_STATE_WIDTH-1:0] state, input int n);
        prng_res_t r;
        logic [PRNG_STATE_WIDTH:0] st;
        r.state = state;
        r.bits  = '0;
        for (int i = 0; i < PRNG_MAX_OUT; i++) begin
            if (i < n) begin
                st         = prng_step(r.state);
                r.state    = st[PRNG_STATE_WIDTH:1];
                r.bits[i]  = st[0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/masked_sbox_random_gen_if.sv
// Seed / randomness bus between the generator and its seed source and consumer.
// Signal bundle only: no latency, no flow control of its own.
interface masked_sbox_random_gen_if import masked_sbox_random_gen_pkg::*; #(
    parameter int NUM_RANDOM = 16
);
    logic [PRNG_STATE_WIDTH-1:0] in_seed;
    logic                        in_seed_valid;
    logic                        out_seed_ready;
    logic                        in_enable;
    logic [NUM_RANDOM-1:0]       out_random;
    logic                        out_random_valid;
    logic                        out_reseed_req;

    modport master (
        output in_seed, in_seed_valid, in_enable,
        input  out_seed_ready, out_random, out_random_valid, out_reseed_req
    );

    modport slave (
        input  in_seed, in_seed_valid, in_enable,
        output out_seed_ready, out_random, out_random_valid, out_reseed_req
    );
endinterface

// File: rtl/masked_sbox_random_gen_lfsr.sv
// Unrolled 128-bit Fibonacci LFSR: STEPS steps of next state plus the bits emitted on the way.
// Purely combinational, no flow control.
module prng_lfsr128_unrolled import masked_sbox_random_gen_pkg::*; #(
    parameter int STEPS = 16
) (
    input  logic [PRNG_STATE_WIDTH-1:0] state_i,
    output logic [PRNG_STATE_WIDTH-1:0] next_state_o,
    output logic [STEPS-1:0]            word_o
);
    logic [PRNG_STATE_WIDTH-1:0] s;

    always_comb begin
        s      = state_i;
        word_o = '0;
        for (int i = 0; i < STEPS; i++) begin
            {s, word_o[i]} = prng_step(s);
        end
        next_state_o = s;
    end
endmodule

// File: rtl/masked_sbox_random_gen.sv
// Seeded, warm-up-gated masking-randomness source; out_random is a direct view of the LFSR state register.
// Valid WARMUP_CYCLES edges after seed accept; a word is replaced on the edge after in_enable, else held.
module masked_sbox_random_gen import masked_sbox_random_gen_pkg::*; #(
    parameter int          NUM_SHARES      = 2,
    parameter stage_type_e STAGE_TYPE      = DEFAULT_STAGE_TYPE,
    parameter int          NUM_RANDOM      = num_canright_inv_random(NUM_SHARES, STAGE_TYPE),
    parameter int          WARMUP_CYCLES   = 16,
    parameter int          RESEED_INTERVAL = 0
) (
    input logic                     in_clock,
    input logic                     in_reset,
    masked_sbox_random_gen_if.slave bus
);
    localparam int WCNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam int RCNT_W = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;

    gen_state_e                  state_q, state_d;
    logic [PRNG_STATE_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_adv, seed_fix;
    logic [WCNT_W-1:0]           wcnt_q, wcnt_d;
    logic [RCNT_W-1:0]           rcnt_q, rcnt_d;
    logic [NUM_RANDOM-1:0]       word;
    logic                        seed_rdy, rnd_vld, seed_acc;

    prng_lfsr128_unrolled #(.STEPS(NUM_RANDOM)) u_lfsr (
        .state_i      (lfsr_q),
        .next_state_o (lfsr_adv),
        .word_o       (word)
    );

    // An all-zero state would lock the LFSR forever
    assign seed_fix = (bus.in_seed == '0) ? PRNG_ZERO_SEED_SUB : bus.in_seed;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        seed_rdy = 1'b0;
        rnd_vld  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                seed_rdy = 1'b1;
            end
            ST_WARMUP: begin
                lfsr_d = lfsr_adv;
                wcnt_d = wcnt_q + 1'b1;
                if (int'(wcnt_q) + 1 >= WARMUP_CYCLES) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                seed_rdy = 1'b1;
                rnd_vld  = 1'b1;
                if (bus.in_enable) begin
                    lfsr_d = lfsr_adv;
                    if ((RESEED_INTERVAL != 0) && (int'(rcnt_q) < RESEED_INTERVAL)) begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A seed load takes priority over any advance in the same cycle
        seed_acc = bus.in_seed_valid & seed_rdy;
        if (seed_acc) begin
            lfsr_d  = seed_fix;
            wcnt_d  = '0;
            rcnt_d  = '0;
            state_d = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign bus.out_random       = word;
    assign bus.out_random_valid = rnd_vld;
    assign bus.out_seed_ready   = seed_rdy;
    assign bus.out_reseed_req   = (RESEED_INTERVAL != 0) && (int'(rcnt_q) == RESEED_INTERVAL)
                                  && (state_q == ST_RUN);
endmodule

// File: tb/tb_masked_sbox_random_gen.sv
// Directed/randomized bench: DUT A (no warm-up, no reseed request) and DUT B (16 warm-up cycles, interval 5).
// Reference: the LFSR viewed as its output bit stream x[t+128] = x[t]^x[t+1]^x[t+2]^x[t+7].
module tb_masked_sbox_random_gen;
    import masked_sbox_random_gen_pkg::*;

    localparam int NR = num_canright_inv_random(2, DEFAULT_STAGE_TYPE);
    localparam int WB = 16;
    localparam int RB = 5;
    localparam logic [NR+2:0] RST_OBS = {3'b010, {NR{1'b0}}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    masked_sbox_random_gen_if #(.NUM_RANDOM(NR)) ifa ();
    masked_sbox_random_gen_if #(.NUM_RANDOM(NR)) ifb ();

    masked_sbox_random_gen #(
        .NUM_SHARES(2), .STAGE_TYPE(DEFAULT_STAGE_TYPE), .NUM_RANDOM(NR),
        .WARMUP_CYCLES(0), .RESEED_INTERVAL(0)
    ) dut_a (.in_clock(clk), .in_reset(rst), .bus(ifa.slave));

    masked_sbox_random_gen #(
        .NUM_SHARES(2), .STAGE_TYPE(DEFAULT_STAGE_TYPE), .NUM_RANDOM(NR),
        .WARMUP_CYCLES(WB), .RESEED_INTERVAL(RB)
    ) dut_b (.in_clock(clk), .in_reset(rst), .bus(ifb.slave));

    // {reseed_req, seed_ready, valid, random}
    logic [NR+2:0] obs_a, obs_b;
    assign obs_a = {ifa.out_reseed_req, ifa.out_seed_ready, ifa.out_random_valid, ifa.out_random};
    assign obs_b = {ifb.out_reseed_req, ifb.out_seed_ready, ifb.out_random_valid, ifb.out_random};

    int checks = 0;
    int failures = 0;
    bit stream[$];
    int pos;
    int ncnt;

    task automatic chk(input string tag, input logic [NR+2:0] obs, input logic [NR+2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void mseed(input logic [127:0] sd);
        stream.delete();
        for (int i = 0; i < 128; i++) stream.push_back(sd[127-i]);
        pos = 0;
    endfunction

    function automatic logic [NR-1:0] mword();
        logic [NR-1:0] w;
        int t;
        while (stream.size() < pos + NR) begin
            t = stream.size() - 128;
            stream.push_back(stream[t] ^ stream[t+1] ^ stream[t+2] ^ stream[t+7]);
        end
        for (int j = 0; j < NR; j++) w[j] = stream[pos+j];
        return w;
    endfunction

    task automatic run_a(input string pfx, input int n);
        bit en;
        for (int c = 0; c < n; c++) begin
            en = 1'($urandom_range(0, 1));
            ifa.in_enable = en;
            @(negedge clk);
            if (en) pos += NR;
            chk($sformatf("%s%0d", pfx, c), obs_a, {3'b011, mword()});
        end
    endtask

    task automatic run_b(input string pfx, input int n, input bit force_en);
        bit en;
        for (int c = 0; c < n; c++) begin
            en = force_en ? 1'b1 : 1'($urandom_range(0, 1));
            ifb.in_enable = en;
            @(negedge clk);
            if (en) begin
                pos += NR;
                if (ncnt < RB) ncnt++;
            end
            chk($sformatf("%s%0d", pfx, c), obs_b, {(ncnt == RB), 2'b11, mword()});
        end
    endtask

    // Offer a seed to B, then check nwarm warm-up cycles (and first valid word if warm-up completes)
    task automatic seed_b(input string pfx, input logic [127:0] sd, input bit en_same, input int nwarm);
        ifb.in_seed       = sd;
        ifb.in_seed_valid = 1'b1;
        ifb.in_enable     = en_same;
        mseed(sd);
        ncnt = 0;
        for (int i = 0; i < nwarm; i++) begin
            @(negedge clk);
            ifb.in_seed_valid = 1'b0;
            ifb.in_enable     = 1'($urandom_range(0, 1));
            pos = i * NR;
            chk($sformatf("%s_warm%0d", pfx, i), obs_b, {3'b000, mword()});
        end
        if (nwarm < WB) return;
        @(negedge clk);
        pos = WB * NR;
        chk($sformatf("%s_first_valid", pfx), obs_b, {3'b011, mword()});
    endtask

    initial begin
        logic [127:0] seed_b1, seed_b2;
        logic [NR-1:0] e1;

        ifa.in_seed = '0; ifa.in_seed_valid = 1'b0; ifa.in_enable = 1'b0;
        ifb.in_seed = '0; ifb.in_seed_valid = 1'b0; ifb.in_enable = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_a", obs_a, RST_OBS);
        chk("rst_b", obs_b, RST_OBS);
        @(negedge clk);
        rst = 1'b0;

        // Unseeded: outputs stay at reset values whatever in_enable does
        for (int c = 0; c < 10; c++) begin
            ifa.in_enable = 1'($urandom_range(0, 1));
            ifb.in_enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("idle_a%0d", c), obs_a, RST_OBS);
            chk($sformatf("idle_b%0d", c), obs_b, RST_OBS);
        end

        // DUT A, no warm-up: seed 1 is valid right after the accepting edge
        ifa.in_seed = 128'h1; ifa.in_seed_valid = 1'b1; ifa.in_enable = 1'b1;
        mseed(128'h1);
        @(negedge clk);
        ifa.in_seed_valid = 1'b0;
        e1 = '0;
        for (int j = 0; j < NR; j++) if (j == 127) e1[j] = 1'b1;
        chk("a_seed1_word", {3'b000, ifa.out_random}, {3'b000, e1});
        chk("a_seed1_first", obs_a, {3'b011, mword()});
        run_a("a_run", 40);

        // Zero seed in RUN with in_enable high: seed wins and stream equals the seed-1 stream
        ifa.in_seed = '0; ifa.in_seed_valid = 1'b1; ifa.in_enable = 1'b1;
        mseed(128'h1);
        @(negedge clk);
        ifa.in_seed_valid = 1'b0;
        chk("a_seed0_first", obs_a, {3'b011, mword()});
        run_a("a_zero", 40);

        // DUT B: warm-up, random enables, reseed request
        seed_b1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        seed_b2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        seed_b("b1", seed_b1, 1'b0, WB);
        run_b("b_rand", 12, 1'b0);
        run_b("b_force", 6, 1'b1);
        run_b("b_hold", 8, 1'b0);

        // Reseed during RUN with in_enable high, then reset mid-warm-up (B) and mid-run (A)
        seed_b("b2", seed_b2, 1'b1, 7);
        #2 rst = 1'b1;
        #1;
        chk("a_rst_midrun", obs_a, RST_OBS);
        chk("b_rst_midwarm", obs_b, RST_OBS);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("a_post_rst", obs_a, RST_OBS);
        chk("b_post_rst", obs_b, RST_OBS);

        // Reloading the same seed restarts the identical sequence
        seed_b("b2_again", seed_b2, 1'b0, WB);
        run_b("b_again", 12, 1'b0);
        chk("a_idle_end", obs_a, RST_OBS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
